// File: rtl/da_dds_pkg.sv
// da_dds_pkg: shared types and constants for the DDS DAC sample generator.
//   mode_e     - waveform select (ROM / saw / square / triangle)
//   AMP_W      - width of the gain word
//   AMP_UNITY  - gain value that passes samples through unchanged
//   mid_code() - midscale code of an offset-binary sample of a given width
//   clamp_amp()- limits a gain word to unity
package da_dds_pkg;

  typedef enum logic [1:0] {
    MODE_ROM = 2'd0,
    MODE_SAW = 2'd1,
    MODE_SQR = 2'd2,
    MODE_TRI = 2'd3
  } mode_e;

  localparam int AMP_W = 9;
  localparam logic [AMP_W-1:0] AMP_UNITY = 9'd256;

  function automatic int unsigned mid_code(input int unsigned data_w);
    return 32'd1 << (data_w - 1);
  endfunction

  // Gains above unity are limited so the scaling stage can never overflow.
  function automatic logic [AMP_W-1:0] clamp_amp(input logic [AMP_W-1:0] amp);
    return (amp > AMP_UNITY) ? AMP_UNITY : amp;
  endfunction

endpackage

// File: rtl/da_phase_acc.sv
// da_phase_acc: phase accumulator with a shadowed configuration interface.
// A config word is captured into a shadow register when cfg_valid && cfg_ready
// and is copied to the live registers only at a phase wrap (or at once while
// stopped), so a running waveform never changes mid-period.
// Ports:
//   clk, rst_n             - clock, async active-low reset
//   en                     - run enable (accumulator advances when high)
//   cfg_valid/cfg_ready    - config handshake
//   cfg_ftw/mode/amp       - requested tuning word, waveform, gain
//   mode, amp              - live waveform and gain
//   rd_addr                - registered ROM address
//   phase                  - top DATA_W phase bits, aligned with rd_addr
//   carry                  - wrap flag, aligned with rd_addr
//   valid                  - en at address issue, aligned with rd_addr
module da_phase_acc
  import da_dds_pkg::*;
#(
  parameter int              ACC_W   = 32,
  parameter int              ADDR_W  = 8,
  parameter int              DATA_W  = 8,
  parameter logic [ACC_W-1:0] FTW_RST = ACC_W'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ACC_W-1:0]  cfg_ftw,
  input  logic [1:0]        cfg_mode,
  input  logic [AMP_W-1:0]  cfg_amp,
  output mode_e             mode,
  output logic [AMP_W-1:0]  amp,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] phase,
  output logic              carry,
  output logic              valid
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw;
  logic [ACC_W-1:0] sh_ftw;
  mode_e            sh_mode;
  logic [AMP_W-1:0] sh_amp;
  logic             pending;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic             add_carry;
  logic             apply;
  logic             transfer;

  assign sum       = {1'b0, acc} + {1'b0, ftw};
  assign add_carry = en & sum[ACC_W];
  assign acc_next  = en ? sum[ACC_W-1:0] : acc;

  // Apply waits for a wrap while running; a stopped generator applies at once.
  // Transfer and apply are mutually exclusive because transfer needs !pending.
  assign apply     = pending & (~en | add_carry);
  assign transfer  = cfg_valid & ~pending;
  assign cfg_ready = ~pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      ftw     <= FTW_RST;
      mode    <= MODE_ROM;
      amp     <= AMP_UNITY;
      sh_ftw  <= FTW_RST;
      sh_mode <= MODE_ROM;
      sh_amp  <= AMP_UNITY;
      pending <= 1'b0;
      rd_addr <= '0;
      phase   <= '0;
      carry   <= 1'b0;
      valid   <= 1'b0;
    end else begin
      acc     <= acc_next;
      rd_addr <= acc_next[ACC_W-1 -: ADDR_W];
      phase   <= acc_next[ACC_W-1 -: DATA_W];
      carry   <= add_carry;
      valid   <= en;
      if (apply) begin
        ftw     <= sh_ftw;
        mode    <= sh_mode;
        amp     <= sh_amp;
        pending <= 1'b0;
      end else if (transfer) begin
        sh_ftw  <= cfg_ftw;
        sh_mode <= mode_e'(cfg_mode);
        sh_amp  <= clamp_amp(cfg_amp);
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/da_dds_send.sv
// da_dds_send: DDS sample generator driving a parallel offset-binary DAC.
// The phase accumulator addresses an external wave ROM; the returned sample
// (or a synthesised saw/square/triangle) is gain-scaled about midscale and
// registered onto the DAC pins.
// Ports:
//   clk, rst_n          - sample clock, async active-low reset
//   en                  - run enable
//   cfg_valid/cfg_ready - config handshake; cfg_ftw/cfg_mode/cfg_amp payload
//   rd_addr, rd_data    - external ROM address out / data in (ROM_LAT cycles)
//   da_clk              - DAC clock (same as clk)
//   da_data, da_valid   - registered DAC sample and its running flag
//   wrap                - pulse with the first sample after a phase wrap
module da_dds_send
  import da_dds_pkg::*;
#(
  parameter int               ACC_W   = 32,
  parameter int               ADDR_W  = 8,
  parameter int               DATA_W  = 8,
  parameter int               ROM_LAT = 1,
  parameter logic [ACC_W-1:0] FTW_RST = ACC_W'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ACC_W-1:0]  cfg_ftw,
  input  logic [1:0]        cfg_mode,
  input  logic [AMP_W-1:0]  cfg_amp,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              da_clk,
  output logic [DATA_W-1:0] da_data,
  output logic              da_valid,
  output logic              wrap
);

  localparam logic [DATA_W-1:0] MID = DATA_W'(mid_code(DATA_W));

  mode_e             live_mode;
  logic [AMP_W-1:0]  live_amp;
  logic [DATA_W-1:0] phase;
  logic              acc_carry;
  logic              acc_valid;

  assign da_clk = clk;

  da_phase_acc #(
    .ACC_W   (ACC_W),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .FTW_RST (FTW_RST)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ftw   (cfg_ftw),
    .cfg_mode  (cfg_mode),
    .cfg_amp   (cfg_amp),
    .mode      (live_mode),
    .amp       (live_amp),
    .rd_addr   (rd_addr),
    .phase     (phase),
    .carry     (acc_carry),
    .valid     (acc_valid)
  );

  // Side-band delay line: phase, mode, gain, valid and wrap ride ROM_LAT
  // stages so the last stage lines up with rd_data for the same address.
  logic [DATA_W-1:0] p_dl     [ROM_LAT];
  mode_e             mode_dl  [ROM_LAT];
  logic [AMP_W-1:0]  amp_dl   [ROM_LAT];
  logic              valid_dl [ROM_LAT];
  logic              wrap_dl  [ROM_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        p_dl[i]     <= '0;
        mode_dl[i]  <= MODE_ROM;
        amp_dl[i]   <= AMP_UNITY;
        valid_dl[i] <= 1'b0;
        wrap_dl[i]  <= 1'b0;
      end
    end else begin
      p_dl[0]     <= phase;
      mode_dl[0]  <= live_mode;
      amp_dl[0]   <= live_amp;
      valid_dl[0] <= acc_valid;
      wrap_dl[0]  <= acc_carry;
      for (int i = 1; i < ROM_LAT; i++) begin
        p_dl[i]     <= p_dl[i-1];
        mode_dl[i]  <= mode_dl[i-1];
        amp_dl[i]   <= amp_dl[i-1];
        valid_dl[i] <= valid_dl[i-1];
        wrap_dl[i]  <= wrap_dl[i-1];
      end
    end
  end

  logic [DATA_W-1:0] p_al;
  logic [DATA_W-1:0] p_dbl;
  logic [DATA_W-1:0] sample;

  assign p_al  = p_dl[ROM_LAT-1];
  assign p_dbl = {p_al[DATA_W-2:0], 1'b0};

  // Triangle folds the doubled phase in the upper half so the ramp turns
  // at the MSB and returns symmetrically.
  always_comb begin
    sample = rd_data;
    unique case (mode_dl[ROM_LAT-1])
      MODE_ROM: sample = rd_data;
      MODE_SAW: sample = p_al;
      MODE_SQR: sample = p_al[DATA_W-1] ? '1 : '0;
      MODE_TRI: sample = p_al[DATA_W-1] ? ~p_dbl : p_dbl;
      default:  sample = rd_data;
    endcase
  end

  // Gain about midscale: the true product always fits because gain <= unity,
  // so the wide intermediate only exists to keep the arithmetic signed.
  logic signed [DATA_W:0]    diff;
  logic signed [DATA_W+10:0] diff_ext;
  logic signed [DATA_W+10:0] amp_ext;
  logic signed [DATA_W+10:0] prod;
  logic signed [DATA_W+10:0] shifted;
  logic        [DATA_W-1:0]  scaled;

  assign diff     = $signed({1'b0, sample}) - $signed({1'b0, MID});
  assign diff_ext = (DATA_W+11)'(diff);
  assign amp_ext  = (DATA_W+11)'($signed({1'b0, amp_dl[ROM_LAT-1]}));
  assign prod     = diff_ext * amp_ext;
  assign shifted  = prod >>> 8;
  assign scaled   = MID + shifted[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      da_data  <= MID;
      da_valid <= 1'b0;
      wrap     <= 1'b0;
    end else if (valid_dl[ROM_LAT-1]) begin
      da_data  <= scaled;
      da_valid <= 1'b1;
      wrap     <= wrap_dl[ROM_LAT-1];
    end else begin
      da_data  <= MID;
      da_valid <= 1'b0;
      wrap     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_da_dds_send.sv
// tb_da_dds_send: self-checking bench for da_dds_send. A wave ROM with the
// configured latency feeds the DUT; a behavioural model tracks the phase as
// an integer, applies shadowed configs at wraps, and predicts every DAC
// sample through a fixed-length expectation queue.
module tb_da_dds_send;
  import da_dds_pkg::*;

  localparam int ACC_W   = 32;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int ROM_LAT = 2;
  localparam logic [31:0] FTW_RST = 32'h0100_0000;
  localparam longint unsigned TWO32 = 64'h1_0000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [ACC_W-1:0]  cfg_ftw = '0;
  logic [1:0]        cfg_mode = '0;
  logic [8:0]        cfg_amp = '0;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              da_clk;
  logic [DATA_W-1:0] da_data;
  logic              da_valid;
  logic              wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  da_dds_send #(
    .ACC_W   (ACC_W),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ROM_LAT (ROM_LAT),
    .FTW_RST (FTW_RST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ftw   (cfg_ftw),
    .cfg_mode  (cfg_mode),
    .cfg_amp   (cfg_amp),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .da_clk    (da_clk),
    .da_data   (da_data),
    .da_valid  (da_valid),
    .wrap      (wrap)
  );

  // External wave ROM with ROM_LAT registered stages.
  logic [7:0] rom      [256];
  logic [7:0] rom_pipe [ROM_LAT];

  initial begin
    for (int i = 0; i < ROM_LAT; i++) rom_pipe[i] = 8'h00;
  end

  always @(posedge clk) begin
    rom_pipe[0] <= rom[rd_addr];
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end

  assign rd_data = rom_pipe[ROM_LAT-1];

  // Reference model state
  typedef struct {
    bit valid;
    int data;
    bit wrp;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            exp_now;
  longint unsigned m_acc;
  longint unsigned m_ftw, s_ftw;
  int              m_mode, s_mode;
  int              m_amp, s_amp;
  bit              m_pending;
  bit              m_xfer;
  int              exp_addr;

  function automatic int scaleRef(input int s, input int amp);
    int n, q;
    n = (s - 128) * amp;
    q = n / 256;
    if (n < 0 && (n % 256) != 0) q = q - 1;
    return 128 + q;
  endfunction

  function automatic int waveRef(input int mode, input int p);
    case (mode)
      0:       return int'(rom[p]);
      1:       return p;
      2:       return (p >= 128) ? 255 : 0;
      default: return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
    endcase
  endfunction

  task automatic modelReset();
    exp_t idle;
    m_acc = 0; m_ftw = FTW_RST; s_ftw = FTW_RST;
    m_mode = 0; s_mode = 0; m_amp = 256; s_amp = 256;
    m_pending = 0; m_xfer = 0;
    exp_addr = 0;
    idle.valid = 0; idle.data = 128; idle.wrp = 0;
    exp_q.delete();
    for (int i = 0; i < ROM_LAT + 1; i++) exp_q.push_back(idle);
    exp_now = idle;
  endtask

  // Predicts the effect of the coming clock edge from the driven inputs.
  task automatic modelStep();
    longint unsigned sum;
    bit carry, apply;
    int p;
    exp_t e;
    sum    = m_acc + (en ? m_ftw : 0);
    carry  = en && (sum >= TWO32);
    m_xfer = cfg_valid && !m_pending;
    apply  = m_pending && (!en || carry);
    m_acc  = sum % TWO32;
    if (apply) begin
      m_ftw = s_ftw; m_mode = s_mode; m_amp = s_amp; m_pending = 0;
    end else if (m_xfer) begin
      s_ftw = cfg_ftw; s_mode = int'(cfg_mode);
      s_amp = (cfg_amp > 256) ? 256 : int'(cfg_amp);
      m_pending = 1;
    end
    p = int'(m_acc / (TWO32 / 256));
    exp_addr = p;
    e.valid = en;
    e.data  = en ? scaleRef(waveRef(m_mode, p), m_amp) : 128;
    e.wrp   = carry;
    exp_q.push_back(e);
    exp_now = exp_q.pop_front();
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic v, input logic [31:0] f,
                               input logic [1:0] m, input logic [8:0] a);
    en = e; cfg_valid = v; cfg_ftw = f; cfg_mode = m; cfg_amp = a;
  endtask

  task automatic checkAll();
    checkOutput("da_data",   int'(da_data),   exp_now.data);
    checkOutput("da_valid",  int'(da_valid),  int'(exp_now.valid));
    checkOutput("wrap",      int'(wrap),      int'(exp_now.wrp));
    checkOutput("rd_addr",   int'(rd_addr),   exp_addr);
    checkOutput("cfg_ready", int'(cfg_ready), int'(!m_pending));
  endtask

  task automatic stepCycle();
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
    if (m_xfer) cfg_valid = 1'b0;
  endtask

  task automatic runCycles(input int n, input bit rnd_en);
    for (int i = 0; i < n; i++) begin
      if (rnd_en) en = ($urandom_range(0, 19) != 0);
      stepCycle();
    end
  endtask

  task automatic sendConfig(input logic e, input logic [31:0] f, input logic [1:0] m,
                            input logic [8:0] a);
    int waited;
    bit done;
    applyStimulus(e, 1'b1, f, m, a);
    waited = 0;
    done = 0;
    while (!done && waited < 3000) begin
      stepCycle();
      done = m_xfer;
      waited++;
    end
    checkOutput("cfg_accept_timeout", int'(done), 1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));

    // Reset and idle outputs
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    modelReset();
    checkAll();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    runCycles(3, 0);

    // Default stride: address counts by one and wraps every 256 samples
    en = 1'b1;
    runCycles(300, 0);

    // Doubled stride requested mid-period, takes effect at the next wrap
    sendConfig(1'b1, 32'h0200_0000, 2'd0, 9'd256);
    runCycles(300, 0);

    // Square at unity, half and zero gain
    sendConfig(1'b1, 32'h0100_0000, 2'd2, 9'd256);
    runCycles(300, 0);
    sendConfig(1'b1, 32'h0100_0000, 2'd2, 9'd128);
    runCycles(300, 0);
    sendConfig(1'b1, 32'h0100_0000, 2'd2, 9'd0);
    runCycles(300, 0);

    // Triangle with an over-range gain that clamps to unity
    sendConfig(1'b1, 32'h0100_0000, 2'd3, 9'd300);
    runCycles(600, 0);

    // Zero tuning word: constant address while still valid
    sendConfig(1'b1, 32'h0000_0000, 2'd1, 9'd256);
    runCycles(300, 0);

    // Stop, reconfigure while stopped, resume from the held phase
    en = 1'b0;
    runCycles(10, 0);
    sendConfig(1'b0, 32'h0180_0000, 2'd0, 9'd200);
    runCycles(5, 0);
    en = 1'b1;
    runCycles(200, 0);

    // Random configurations with occasional enable drops
    for (int k = 0; k < 8; k++) begin
      sendConfig(1'b1, $urandom_range(32'h0040_0000, 32'h0800_0000),
                 2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)));
      runCycles($urandom_range(100, 400), 1);
    end

    // Reset mid-run while a config is pending
    en = 1'b1;
    runCycles(20, 0);
    sendConfig(1'b1, 32'h0400_0000, 2'd1, 9'd64);
    runCycles(5, 0);
    checkOutput("pending_before_reset", int'(cfg_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    runCycles(300, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
